lcd_bus_timer: RTL and testbench
================================

Name: lcd_bus_timer

Overview:
Parametrised LCD bus timing generator for HD44780-class character LCDs, driven by the EPC-style active-low strobes nCS/nWR/nRD/RS. It generalises the fixed 2/11-cycle write/read sequencer.
- Programmable setup, enable-width and hold times.
- Optional 4-bit nibble mode.
- Read-data capture.
- Busy/done handshake toward the bus side.
- Release-before-retrigger protection.

It sits between the EPC decode logic and the LCD pins.

Parameters:
T_AS, 2, cycles RS/RW/DB valid before lcd_en rises (>=1)
T_PW, 11, cycles lcd_en held high (>=1)
T_H, 2, cycles RS/RW/DB held after lcd_en falls (>=1)
FOUR_BIT, 0, 1 = transfer each byte as two nibbles on DB[7:4], high nibble first
CNT_W, 6, phase counter width; must hold max(T_AS,T_PW,T_H)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
nCS  in  1  chip select, active low
nWR  in  1  write strobe, active low
nRD  in  1  read strobe, active low
RS  in  1  register select from bus
wdata  in  8  write data from bus
rdata  out  8  captured read data, held until next read
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at transaction completion
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write (1 = read)
lcd_en  out  1  LCD enable
lcd_db_o  out  8  LCD data out (4-bit mode: nibble on [7:4], [3:0]=0)
lcd_db_oe  out  1  data bus output enable
lcd_db_i  in  8  LCD data in

Behaviour:
- Reset (async): state IDLE, counters 0. All outputs 0, including rdata and lcd_db_oe. Reset during any phase drops lcd_en immediately; no partial completion and no done pulse.
- States:
  - IDLE: accepts a request when nCS=0 and exactly one of nWR/nRD=0. nWR=nRD=0 is ignored: no transaction, no flag.
  - On accept (edge E0): latch RS, direction and wdata; go to SETUP.
    - lcd_rs, lcd_rw and lcd_db_o are valid from E0.
    - lcd_db_oe=1 for writes, 0 for reads.
  - SETUP: lasts T_AS cycles. lcd_en rises at edge E0+T_AS (enter EN_HI).
  - EN_HI: lasts T_PW cycles. lcd_en falls at edge E0+T_AS+T_PW (enter HOLD).
    - Reads: lcd_db_i is sampled at that same falling edge.
    - 8-bit mode: captured into rdata[7:0].
    - 4-bit mode: first nibble DB_i[7:4] goes to rdata[7:4], second to rdata[3:0].
  - HOLD: lasts T_H cycles.
    - 4-bit mode, first nibble: return to SETUP with the low nibble of wdata on lcd_db_o[7:4].
    - Otherwise: go to WAIT_REL with done=1 for exactly one cycle.
  - WAIT_REL:
    - lcd_db_oe=0, lcd_rw=0, lcd_en=0; lcd_rs holds its last value.
    - Returns to IDLE once nCS=1, or nWR=1 and nRD=1, is sampled. The next acceptance can happen no earlier than the following cycle.
    - Strobes held low therefore never retrigger a transaction.
- Latency from E0 to the done-high edge:
  - 8-bit mode: N = T_AS+T_PW+T_H (default 15).
  - 4-bit mode: 2N (default 30).
- rdata changes only on the read sample edges, and is stable whenever done=1.
- Bus strobes or RS changing mid-transaction are ignored; the latched values are used.
- RS=0 reads (busy flag) use the same full timing as all other transfers; there is no shortcut path.
- Counter: loads 0 on each phase entry and ends each phase at count==T_x-1. No wrap occurs while CNT_W is sized correctly.

Decomposition:
- Package lcd_pkg: state enum (IDLE, SETUP, EN_HI, HOLD, WAIT_REL), default timing constants (2/11/2), and nibble-select constants.
- One sub-module is natural: lcd_phase_counter (load, enable, terminal-count compare against a runtime limit), instantiated once.

Test Plan:
1. Write, defaults: nCS=0, nWR=0, RS=1, wdata=0x41.
   - lcd_rs=1, lcd_rw=0, lcd_db_o=0x41, lcd_db_oe=1 from E0.
   - lcd_en high on edges E0+2..E0+13.
   - done pulse at E0+15; busy=1 from E0 until release.
2. Read: nCS=0, nRD=0, RS=0, lcd_db_i=0x80 held.
   - lcd_rw=1, lcd_db_oe=0 throughout.
   - rdata=0x80 at E0+13; done at E0+15.
3. FOUR_BIT=1 write, wdata=0x3C.
   - Two lcd_en pulses of 11 cycles each.
   - lcd_db_o[7:4]=0x3 during the first pulse, 0xC during the second.
   - done at E0+30.
   - Repeat as a read with lcd_db_i[7:4]=0xA then 0x5: rdata=0xA5.
4. Strobes held low 40 cycles after a write.
   - Exactly one lcd_en pulse.
   - After nCS=1 for 1 cycle, a new nWR request is accepted.
5. nCS=0, nWR=0, nRD=0 for 20 cycles.
   - No lcd_en pulse; busy=0 and done=0 throughout.
6. rst pulsed at E0+6 during EN_HI.
   - lcd_en=0, busy=0 and lcd_db_oe=0 asynchronously; no done pulse.
   - The next write completes with nominal timing (done at E0'+15).

Source files
------------

// File: rtl/lcd_pkg.sv
// ============================================================================
//  Module   : lcd_pkg
//  Purpose  : Shared types and default timing for the LCD bus timer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    EN_HI    = 3'd2,
    HOLD     = 3'd3,
    WAIT_REL = 3'd4
  } lcdState_t;

  localparam int c_T_AS_DEFAULT = 2;
  localparam int c_T_PW_DEFAULT = 11;
  localparam int c_T_H_DEFAULT  = 2;

  // Which half of the byte is on DB[7:4] in nibble mode
  localparam logic c_NIB_HIGH = 1'b0;
  localparam logic c_NIB_LOW  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lcd_phase_counter.sv
// ============================================================================
//  Module   : lcd_phase_counter
//  Purpose  : Phase cycle counter with load-to-zero and terminal compare.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_phase_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign terminal = (r_count == limit);

endmodule

`default_nettype wire

// File: rtl/lcd_bus_timer.sv
// ============================================================================
//  Module   : lcd_bus_timer
//  Purpose  : HD44780 bus timing generator driven by EPC-style strobes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_bus_timer
  import lcd_pkg::*;
#(
  parameter int T_AS     = c_T_AS_DEFAULT,
  parameter int T_PW     = c_T_PW_DEFAULT,
  parameter int T_H      = c_T_H_DEFAULT,
  parameter int FOUR_BIT = 0,
  parameter int CNT_W    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nCS,
  input  logic       nWR,
  input  logic       nRD,
  input  logic       RS,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_db_o,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_i
);

  lcdState_t        r_state, w_nextState;
  logic             r_rs, r_rw, r_nibble, r_done;
  logic [7:0]       r_wdata, r_rdata;
  logic [CNT_W-1:0] w_limit;
  logic             w_tc, w_active, w_accept, w_phaseEnd;
  logic             w_capture, w_nextNibble, w_finish;
  logic [3:0]       w_nibData;

  // A request needs exactly one strobe; both low is treated as no request
  wire w_request = ~nCS & (nWR ^ nRD);
  wire w_release = nCS | (nWR & nRD);

  lcd_phase_counter #(.CNT_W(CNT_W)) u_phaseCounter (
    .clk      (clk),
    .rst      (rst),
    .load     (w_accept | w_phaseEnd),
    .enable   (w_active),
    .limit    (w_limit),
    .terminal (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_limit      = '0;
    w_active     = 1'b0;
    w_accept     = 1'b0;
    w_phaseEnd   = 1'b0;
    w_capture    = 1'b0;
    w_nextNibble = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_request) begin
          w_accept    = 1'b1;
          w_nextState = SETUP;
        end
      end
      SETUP: begin
        w_active   = 1'b1;
        w_limit    = CNT_W'(T_AS - 1);
        w_phaseEnd = w_tc;
        if (w_tc) w_nextState = EN_HI;
      end
      EN_HI: begin
        w_active   = 1'b1;
        w_limit    = CNT_W'(T_PW - 1);
        w_phaseEnd = w_tc;
        w_capture  = w_tc & r_rw;
        if (w_tc) w_nextState = HOLD;
      end
      HOLD: begin
        w_active   = 1'b1;
        w_limit    = CNT_W'(T_H - 1);
        w_phaseEnd = w_tc;
        if (w_tc) begin
          if (FOUR_BIT != 0 && r_nibble == c_NIB_HIGH) begin
            w_nextNibble = 1'b1;
            w_nextState  = SETUP;
          end else begin
            w_finish    = 1'b1;
            w_nextState = WAIT_REL;
          end
        end
      end
      WAIT_REL: begin
        if (w_release) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs     <= 1'b0;
      r_rw     <= 1'b0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_nibble <= c_NIB_HIGH;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_rs     <= RS;
        r_rw     <= ~nRD;
        r_wdata  <= wdata;
        r_nibble <= c_NIB_HIGH;
      end
      if (w_nextNibble) r_nibble <= c_NIB_LOW;
      // Nibble-mode reads always arrive on DB[7:4]
      if (w_capture) begin
        if (FOUR_BIT != 0) begin
          if (r_nibble == c_NIB_HIGH) r_rdata[7:4] <= lcd_db_i[7:4];
          else                        r_rdata[3:0] <= lcd_db_i[7:4];
        end else begin
          r_rdata <= lcd_db_i;
        end
      end
    end
  end

  assign w_nibData = (r_nibble == c_NIB_HIGH) ? r_wdata[7:4] : r_wdata[3:0];

  assign rdata     = r_rdata;
  assign done      = r_done;
  assign busy      = (r_state != IDLE);
  assign lcd_en    = (r_state == EN_HI);
  assign lcd_rs    = r_rs;
  assign lcd_rw    = w_active & r_rw;
  assign lcd_db_oe = w_active & ~r_rw;
  assign lcd_db_o  = (FOUR_BIT != 0) ? {w_nibData, 4'h0} : r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_timer.sv
// ============================================================================
//  Module   : tb_lcd_bus_timer
//  Purpose  : Self-checking bench for lcd_bus_timer, 8-bit and nibble builds.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_bus_timer;

  localparam int T_AS  = 2;
  localparam int T_PW  = 11;
  localparam int T_H   = 2;
  localparam int N_CYC = T_AS + T_PW + T_H;

  logic       clk = 1'b0;
  logic       rst;
  logic       nCS [2], nWR [2], nRD [2], RS [2];
  logic [7:0] wdata [2], rdata [2], dbO [2], dbI [2];
  logic       busy [2], done [2], lcdRs [2], lcdRw [2], lcdEn [2], dbOe [2];
  logic [7:0] expRdata [2];

  int nChecks = 0;
  int nBad    = 0;

  always #5 clk = ~clk;

  lcd_bus_timer #(.FOUR_BIT(0)) dut8 (
    .clk(clk), .rst(rst), .nCS(nCS[0]), .nWR(nWR[0]), .nRD(nRD[0]), .RS(RS[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .busy(busy[0]), .done(done[0]),
    .lcd_rs(lcdRs[0]), .lcd_rw(lcdRw[0]), .lcd_en(lcdEn[0]), .lcd_db_o(dbO[0]),
    .lcd_db_oe(dbOe[0]), .lcd_db_i(dbI[0])
  );

  lcd_bus_timer #(.FOUR_BIT(1)) dut4 (
    .clk(clk), .rst(rst), .nCS(nCS[1]), .nWR(nWR[1]), .nRD(nRD[1]), .RS(RS[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .busy(busy[1]), .done(done[1]),
    .lcd_rs(lcdRs[1]), .lcd_rw(lcdRw[1]), .lcd_en(lcdEn[1]), .lcd_db_o(dbO[1]),
    .lcd_db_oe(dbOe[1]), .lcd_db_i(dbI[1])
  );

  // One transaction on build m, checked cycle by cycle against the timing
  // rules: enable high for phase offsets [T_AS, T_AS+T_PW) of every byte/nibble
  // slot, done exactly at the end of the last slot, strobes held `hold` extra cycles.
  task automatic runTxn(input int m, input bit isRead, input bit rsv,
                        input logic [7:0] wd, input logic [7:0] rd, input int hold);
    int         nib;
    int         tot;
    int         phase;
    int         p;
    int         enCount;
    logic       prevEn;
    logic       expEn, expDone, expRw, expOe;
    logic [7:0] expDb;
    nib     = (m == 1) ? 2 : 1;
    tot     = nib * N_CYC;
    enCount = 0;
    prevEn  = 1'b0;
    nCS[m]   = 1'b0;
    nWR[m]   = isRead;
    nRD[m]   = ~isRead;
    RS[m]    = rsv;
    wdata[m] = wd;
    dbI[m]   = (m == 1) ? {rd[7:4], 4'($urandom)} : rd;
    for (int k = 0; k <= tot + hold; k++) begin
      @(negedge clk);
      phase   = k % N_CYC;
      p       = k / N_CYC;
      expEn   = (k < tot) && (phase >= T_AS) && (phase < T_AS + T_PW);
      expDone = (k == tot);
      expRw   = (k < tot) && isRead;
      expOe   = (k < tot) && !isRead;
      if (isRead && k < tot && phase == T_AS + T_PW) begin
        if (m == 0)      expRdata[0]      = rd;
        else if (p == 0) expRdata[1][7:4] = rd[7:4];
        else             expRdata[1][3:0] = rd[3:0];
      end
      nChecks++;
      if (lcdEn[m] !== expEn) begin
        nBad++;
        $display("FAIL lcd_en m=%0d k=%0d got=%b want=%b", m, k, lcdEn[m], expEn);
      end
      nChecks++;
      if (done[m] !== expDone) begin
        nBad++;
        $display("FAIL done m=%0d k=%0d got=%b want=%b", m, k, done[m], expDone);
      end
      nChecks++;
      if (busy[m] !== 1'b1) begin
        nBad++;
        $display("FAIL busy m=%0d k=%0d got=%b want=1", m, k, busy[m]);
      end
      nChecks++;
      if (lcdRw[m] !== expRw || dbOe[m] !== expOe) begin
        nBad++;
        $display("FAIL rw_oe m=%0d k=%0d got=%b%b want=%b%b", m, k, lcdRw[m], dbOe[m], expRw, expOe);
      end
      nChecks++;
      if (lcdRs[m] !== rsv) begin
        nBad++;
        $display("FAIL lcd_rs m=%0d k=%0d got=%b want=%b", m, k, lcdRs[m], rsv);
      end
      nChecks++;
      if (rdata[m] !== expRdata[m]) begin
        nBad++;
        $display("FAIL rdata m=%0d k=%0d got=%h want=%h", m, k, rdata[m], expRdata[m]);
      end
      if (!isRead && k < tot) begin
        expDb = (m == 0) ? wd : {((p == 0) ? wd[7:4] : wd[3:0]), 4'h0};
        nChecks++;
        if (dbO[m] !== expDb) begin
          nBad++;
          $display("FAIL lcd_db_o m=%0d k=%0d got=%h want=%h", m, k, dbO[m], expDb);
        end
      end
      if (lcdEn[m] && !prevEn) enCount++;
      prevEn = lcdEn[m];
      RS[m]    = 1'($urandom);
      wdata[m] = 8'($urandom);
      if (m == 1 && k == T_AS + T_PW + 1) dbI[1] = {rd[3:0], 4'($urandom)};
    end
    nChecks++;
    if (enCount != nib) begin
      nBad++;
      $display("FAIL en_pulses m=%0d got=%0d want=%0d", m, enCount, nib);
    end
    nCS[m] = 1'b1;
    nWR[m] = 1'b1;
    nRD[m] = 1'b1;
    @(negedge clk);
    nChecks++;
    if (busy[m] !== 1'b0 || done[m] !== 1'b0 || lcdEn[m] !== 1'b0) begin
      nBad++;
      $display("FAIL release m=%0d got busy=%b done=%b en=%b want 000", m, busy[m], done[m], lcdEn[m]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      nCS[m] = 1'b1; nWR[m] = 1'b1; nRD[m] = 1'b1; RS[m] = 1'b0;
      wdata[m] = 8'h00; dbI[m] = 8'h00; expRdata[m] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      nChecks++;
      if ({rdata[m], dbO[m], busy[m], done[m], lcdRs[m], lcdRw[m], lcdEn[m], dbOe[m]} !== 22'h0) begin
        nBad++;
        $display("FAIL reset_outputs m=%0d got rdata=%h db=%h bdrwe=%b%b%b%b%b%b want all 0", m,
                 rdata[m], dbO[m], busy[m], done[m], lcdRs[m], lcdRw[m], lcdEn[m], dbOe[m]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    runTxn(0, 1'b0, 1'b1, 8'h41, 8'h00, 0);
    runTxn(0, 1'b0, 1'($urandom), 8'($urandom), 8'h00, 2);
  endtask

  task automatic test_read();
    runTxn(0, 1'b1, 1'b0, 8'h00, 8'h80, 0);
    runTxn(0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 1);
  endtask

  task automatic test_four_bit();
    runTxn(1, 1'b0, 1'b1, 8'h3C, 8'h00, 0);
    runTxn(1, 1'b1, 1'b0, 8'h00, 8'hA5, 0);
  endtask

  task automatic test_back_to_back();
    runTxn(0, 1'b0, 1'b1, 8'($urandom), 8'h00, 40);
    runTxn(0, 1'b0, 1'b0, 8'($urandom), 8'h00, 0);
  endtask

  task automatic test_both_strobes();
    for (int m = 0; m < 2; m++) begin
      nCS[m] = 1'b0; nWR[m] = 1'b0; nRD[m] = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        nChecks++;
        if (lcdEn[m] !== 1'b0 || busy[m] !== 1'b0 || done[m] !== 1'b0) begin
          nBad++;
          $display("FAIL both_strobes m=%0d k=%0d got en=%b busy=%b done=%b want 000", m, k,
                   lcdEn[m], busy[m], done[m]);
        end
      end
      nCS[m] = 1'b1; nWR[m] = 1'b1; nRD[m] = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    nCS[0] = 1'b0; nWR[0] = 1'b0; nRD[0] = 1'b1; RS[0] = 1'b1; wdata[0] = 8'h5A;
    repeat (6) @(negedge clk);
    nChecks++;
    if (lcdEn[0] !== 1'b1) begin
      nBad++;
      $display("FAIL pre_reset_en got=%b want=1", lcdEn[0]);
    end
    #2 rst = 1'b1;
    #1;
    nChecks++;
    if (lcdEn[0] !== 1'b0 || busy[0] !== 1'b0 || dbOe[0] !== 1'b0 || done[0] !== 1'b0) begin
      nBad++;
      $display("FAIL async_reset got en=%b busy=%b oe=%b done=%b want 0000",
               lcdEn[0], busy[0], dbOe[0], done[0]);
    end
    nCS[0] = 1'b1; nWR[0] = 1'b1;
    expRdata[0] = 8'h00;
    expRdata[1] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      nChecks++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        nBad++;
        $display("FAIL post_reset k=%0d got done=%b busy=%b want 00", k, done[0], busy[0]);
      end
    end
    runTxn(0, 1'b0, 1'b1, 8'h5A, 8'h00, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      runTxn($urandom_range(0, 1), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_four_bit();
    test_back_to_back();
    test_both_strobes();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

`default_nettype wire
